// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and sizing helpers.
package serial_adder_pkg;

    // Controller states. The fourth code (2'd3) is never entered and decodes to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Number of clock cycles needed to walk a WIDTH-bit operand STEP bits at a time.
    function automatic int steps_of(input int width, input int step);
        return width / step;
    endfunction

    // Slice counter width: enough to index every slice, never narrower than one bit.
    function automatic int cnt_width(input int steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_fa_chain.sv
// Ripple chain of STEP full adders: the only arithmetic in the serial adder datapath.
module serial_adder_fa_chain #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] x,
    input  logic [STEP-1:0] y,
    input  logic            ci,
    output logic [STEP-1:0] s,
    output logic            co,
    output logic            c_top
);

    // carry[i] is the carry into bit i; carry[STEP] leaves the chain.
    logic [STEP:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < STEP; i++) begin : g_fa
        assign s[i]       = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign co    = carry[STEP];
    // Carry into the top bit of the slice; on the last slice this is the carry into the operand MSB.
    assign c_top = carry[STEP-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder computing a + b + c_in on WIDTH-bit operands, STEP bits per clock.
// A start pulse in IDLE captures the operands; done pulses for one cycle when the
// registered sum, carry-out and signed overflow are valid. Results hold until the
// next completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int STEPS = steps_of(WIDTH, STEP);
    localparam int CNT_W = cnt_width(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    // Reject parameter sets that cannot be walked in whole slices.
    if (WIDTH < 1 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_param_check
        $error("serial_adder: STEP must be >= 1 and divide WIDTH exactly");
    end

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic             last;

    logic [STEP-1:0]  slice_s;
    logic             slice_co;
    logic             slice_ctop;
    logic [WIDTH-1:0] s_next;

    assign last = (cnt == LAST);

    serial_adder_fa_chain #(
        .STEP (STEP)
    ) u_chain (
        .x     (a_sh[STEP-1:0]),
        .y     (b_sh[STEP-1:0]),
        .ci    (carry),
        .s     (slice_s),
        .co    (slice_co),
        .c_top (slice_ctop)
    );

    // New slice sums enter from the MSB end so that after STEPS slices the LSB slice
    // has reached bit 0. A single-slice adder has nothing to shift.
    if (STEP == WIDTH) begin : g_single
        assign s_next = slice_s;
    end else begin : g_multi
        assign s_next = {slice_s, s_sh[WIDTH-1:STEP]};
    end

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update from pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake decode.
    // NOTE: every output of this block gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_nx = S_IDLE;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                ready    = 1'b1;
                state_nx = start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                busy     = 1'b1;
                state_nx = last ? S_DONE : S_RUN;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                // Unused code behaves as IDLE and recovers on the next edge.
                ready    = 1'b1;
                state_nx = start ? S_RUN : S_IDLE;
            end
        endcase
    end

    // Operand shift registers, running carry and slice counter.
    // NOTE: these are plain flops, not a memory array, so all of them are reset;
    // an operation in flight is discarded cleanly on rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    a_sh  <= a_sh >> STEP;
                    b_sh  <= b_sh >> STEP;
                    s_sh  <= s_next;
                    carry <= slice_co;
                    cnt   <= cnt + 1'b1;
                end
                S_DONE: begin
                    // Hold; nothing to do until the controller returns to IDLE.
                end
                default: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Result registers: committed only on the edge that adds the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (state == S_RUN && last) begin
            sum      <= s_next;
            c_out    <= slice_co;
            overflow <= slice_ctop ^ slice_co;
        end
    end

endmodule
